// File: rtl/uart16_transmitter.sv
// uart16_transmitter: sends a 16-bit word as two back-to-back 8N1 UART frames
//   Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit per frame).
//   Parameters: TICKS_PER_BIT (clk cycles per bit, 2..256), HIGH_BYTE_FIRST (0: in[7:0] first).
//   Ports: clk (16x baud clock), rst (sync active-high), en (low aborts to idle),
//          start (request, sampled in idle), in (word, latched on accept),
//          out (registered TX line, idles high), busy (word in flight), done (1-cycle completion pulse).
module uart16_transmitter #(
  parameter int TICKS_PER_BIT = 16,
  parameter bit HIGH_BYTE_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        start,
  input  logic [15:0] in,
  output logic        out,
  output logic        busy,
  output logic        done
);
  localparam int TW = (TICKS_PER_BIT > 2) ? $clog2(TICKS_PER_BIT) : 1;
  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
`ifdef UART_TX_PARITY_EN
    PARITY_BIT,
`endif
    STOP_BIT
  } state_t;
  state_t state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic byte_q, byte_d;
  logic [15:0] sh_q, sh_d;
  logic out_q, out_d, busy_q, busy_d, done_q, done_d;
  logic tick_last, par_bit;
  logic [7:0] cur;
  assign tick_last = tick_q == TW'(TICKS_PER_BIT - 1);
  assign out = out_q;
  assign busy = busy_q;
  assign done = done_q;
  always_comb begin
    state_d = state_q;
    tick_d = tick_last ? '0 : tick_q + 1'b1;
    bit_d = bit_q;
    byte_d = byte_q;
    sh_d = sh_q;
    busy_d = busy_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        tick_d = '0;
        if (start) begin
          state_d = START_BIT;
          busy_d = 1'b1;
          bit_d = '0;
          byte_d = 1'b0;
          // The shift register always holds the first-sent byte in [7:0].
          sh_d = HIGH_BYTE_FIRST ? {in[7:0], in[15:8]} : in;
        end
      end
      START_BIT: if (tick_last) state_d = DATA_BITS;
      DATA_BITS: if (tick_last) begin
        bit_d = bit_q + 3'd1;
`ifdef UART_TX_PARITY_EN
        if (bit_q == 3'd7) state_d = PARITY_BIT;
`else
        if (bit_q == 3'd7) state_d = STOP_BIT;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY_BIT: if (tick_last) state_d = STOP_BIT;
`endif
      STOP_BIT: if (tick_last) begin
        byte_d = ~byte_q;
        state_d = byte_q ? IDLE : START_BIT;
        busy_d = ~byte_q;
        done_d = byte_q;
      end
      default: state_d = IDLE;
    endcase
    if (!en) begin
      state_d = IDLE;
      tick_d = '0;
      bit_d = '0;
      byte_d = 1'b0;
      busy_d = 1'b0;
      done_d = 1'b0;
    end
    // The line level is derived from the next state so out is a clean register.
    cur = byte_d ? sh_d[15:8] : sh_d[7:0];
`ifdef UART_TX_PARITY_EN
    par_bit = state_d == PARITY_BIT;
`else
    par_bit = 1'b0;
`endif
    out_d = (state_d == START_BIT) ? 1'b0 : (state_d == DATA_BITS) ? cur[bit_d] : par_bit ? ^cur : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q <= '0;
      bit_q <= '0;
      byte_q <= 1'b0;
      sh_q <= '0;
      out_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q <= tick_d;
      bit_q <= bit_d;
      byte_q <= byte_d;
      sh_q <= sh_d;
      out_q <= out_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_uart16_transmitter.sv
// tb_uart16_transmitter: scoreboard bench for uart16_transmitter, both byte orders side by side
module tb_uart16_transmitter;
  localparam int TPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int WORD = 2 * FB * TPB;
  typedef struct {
    logic [15:0] w;
    int t;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, en = 1'b1, start = 1'b0;
  logic [15:0] din = 16'h0;
  logic [1:0] txo, bsy, dn;
  exp_t exp_q[2][$];
  int nvec = 0, miss = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input bit ok, input string name, input int act, input int req);
    nvec++;
    if (!ok) begin
      miss++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask
  // Reference line level at sample i of a word: frames of start, 8 data LSB first, [parity], stop.
  function automatic logic exp_bit(input logic [15:0] w, input int hbf, input int i);
    int f = i / (FB * TPB);
    int b = (i % (FB * TPB)) / TPB;
    logic [7:0] by = ((f == 0) == (hbf == 0)) ? w[7:0] : w[15:8];
    if (b == 0) return 1'b0;
    if (b <= 8) return by[b-1];
    if (b == 9 && FB == 11) return ^by;
    return 1'b1;
  endfunction
  for (genvar g = 0; g < 2; g++) begin : g_dut
    uart16_transmitter #(.TICKS_PER_BIT(TPB), .HIGH_BYTE_FIRST(g == 1)) u_dut (
      .clk(clk), .rst(rst), .en(en), .start(start), .in(din),
      .out(txo[g]), .busy(bsy[g]), .done(dn[g])
    );
    logic cap[$];
    bit pd;
    initial begin : mon
      exp_t e;
      int bad;
      forever begin
        @(negedge clk);
        if (pd) chk(dn[g] == 1'b0, $sformatf("done_width dut%0d", g), dn[g], 0);
        pd = dn[g];
        if (dn[g]) begin
          if (exp_q[g].size() == 0) chk(1'b0, $sformatf("unexpected_done dut%0d", g), 1, 0);
          else begin
            e = exp_q[g].pop_front();
            bad = 0;
            for (int i = 0; i < WORD; i++) if (i >= cap.size() || cap[i] !== exp_bit(e.w, g, i)) bad++;
            chk(cap.size() == WORD && bad == 0, $sformatf("line dut%0d word %h bad_samples", g, e.w), bad + (cap.size() == WORD ? 0 : 1000), 0);
            chk(cyc == e.t + WORD, $sformatf("done_time dut%0d", g), cyc - e.t, WORD);
            chk(txo[g] == 1'b1, $sformatf("done_out dut%0d", g), txo[g], 1);
          end
          cap.delete();
        end else if (bsy[g]) cap.push_back(txo[g]);
        else cap.delete();
      end
    end
  end
  task automatic push(input logic [15:0] w);
    exp_q[0].push_back('{w, cyc});
    exp_q[1].push_back('{w, cyc});
  endtask
  task automatic send(input logic [15:0] w);
    @(negedge clk);
    din = w;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    push(w);
    chk(bsy == 2'b11 && txo == 2'b00, "accept", {bsy, txo}, 4'b1100);
  endtask
  task automatic wait_done();
    for (int i = 0; i < WORD + 20; i++) begin
      @(negedge clk);
      if (dn[0]) return;
    end
    chk(1'b0, "done_timeout", 0, 1);
  endtask
  initial begin
    int bad;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (txo != 2'b11 || bsy != 2'b00 || dn != 2'b00) bad++;
    end
    chk(bad == 0, "idle_after_reset bad_cycles", bad, 0);
    send(16'hA55A);
    wait_done();
    send(16'h1234);
    wait_done();
`ifdef UART_TX_PARITY_EN
    send(16'h0701);
    wait_done();
`endif
    send(16'h00FF);
    repeat (49) @(negedge clk);
    din = 16'hFFFF;
    start = 1'b1;
    @(negedge clk);
    din = 16'h8001;
    for (int i = 0; i < WORD; i++) begin
      @(negedge clk);
      if (dn[0]) break;
    end
    chk(dn == 2'b11 && bsy == 2'b00, "b2b_done", {dn, bsy}, 4'b1100);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    push(16'h8001);
    chk(bsy == 2'b11 && txo == 2'b00, "b2b_no_gap", {bsy, txo}, 4'b1100);
    wait_done();
    send(16'hC3E7);
    repeat (98) @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    void'(exp_q[0].pop_back());
    void'(exp_q[1].pop_back());
    chk(txo == 2'b11 && bsy == 2'b00 && dn == 2'b00, "abort", {txo, bsy, dn}, 6'b110000);
    en = 1'b1;
    bad = 0;
    for (int i = 0; i < WORD + 20; i++) begin
      @(negedge clk);
      if (dn != 2'b00 || bsy != 2'b00) bad++;
    end
    chk(bad == 0, "abort_quiet bad_cycles", bad, 0);
    send(16'h5A3C);
    wait_done();
    for (int k = 0; k < 10; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(16'($urandom));
      wait_done();
    end
    repeat (5) @(negedge clk);
    chk(exp_q[0].size() == 0 && exp_q[1].size() == 0, "pending_words", exp_q[0].size() + exp_q[1].size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, miss);
    $finish;
  end
endmodule
